conv_parallel_to_seq: RTL

CONV_PARALLEL_TO_SEQ -- requirements
Module: conv_parallel_to_seq

---
 rtl/conv_parallel_to_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/conv_parallel_to_seq.sv
// Parallel-to-serial pixel converter: takes p_words-wide beats and emits one pixel per cycle,
// tagging the first pixel of a frame (sof_out) and the last pixel of each image line (eol_out).
module conv_parallel_to_seq #(
  parameter int C_ROW_SIZE = 8,
  parameter int p_dataBits = 8,
  parameter int p_words    = 9
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [p_words*p_dataBits-1:0] data_in,
  input  logic                          valid_in,
  input  logic                          sof_in,
  output logic                          busy_out,
  output logic [p_dataBits-1:0]         data_out,
  output logic                          valid_out,
  output logic                          sof_out,
  output logic                          eol_out,
  input  logic                          busy_in
);

  localparam int IDX_W = $clog2(p_words);
  localparam int COL_W = (C_ROW_SIZE > 1) ? $clog2(C_ROW_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_words - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(C_ROW_SIZE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic                          sof_q, sof_d;
  logic [p_words*p_dataBits-1:0] beat_q, beat_d;
  logic [COL_W-1:0]              col_eff;
  logic                          out_xfer;
  logic                          in_xfer;
  logic [p_dataBits-1:0]         word_arr [p_words];

  generate
    for (genvar gi = 0; gi < p_words; gi++) begin : g_words
      assign word_arr[gi] = beat_q[gi*p_dataBits +: p_dataBits];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    col_d     = col_q;
    sof_d     = sof_q;
    beat_d    = beat_q;
    valid_out = (state_q == ST_SHIFT);
    data_out  = '0;
    sof_out   = 1'b0;
    eol_out   = 1'b0;
    busy_out  = 1'b0;
    col_eff   = col_q;

    if (valid_out) begin
      data_out = word_arr[idx_q];
      sof_out  = sof_q && (idx_q == '0);
      // A frame start forces the line position back to column 0.
      if (sof_out) col_eff = '0;
      eol_out  = (col_eff == LAST_COL);
      busy_out = !((idx_q == LAST_IDX) && !busy_in);
    end
    if (i_rst) busy_out = 1'b1;

    out_xfer = valid_out && !busy_in;
    in_xfer  = valid_in && !busy_out;

    if (out_xfer) begin
      col_d = (col_eff == LAST_COL) ? '0 : col_eff + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Loading on the last word's transfer keeps the stream bubble-free.
    if (in_xfer) begin
      beat_d  = data_in;
      idx_d   = '0;
      sof_d   = sof_in;
      state_d = ST_SHIFT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      sof_q   <= sof_d;
    end
  end

  always_ff @(posedge i_clk) begin
    beat_q <= beat_d;
  end

endmodule
